updn_counter_mod: RTL and testbench

UPDN_COUNTER_MOD -- requirements
Module: updn_counter_mod

---
 rtl/updn_counter_mod.sv | 86 ++++++++
 tb/tb_updn_counter_mod.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/updn_counter_mod.sv
// Up/down counter with synchronous load, clamp-to-MAX and a registered boundary flag.
// Boundary mode: wrap by default; define UPDN_CNT_SAT_EN for saturating boundaries.
module updn_counter_mod #(
    parameter int unsigned     WIDTH = 4,
    parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sel,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc
);

    localparam logic [WIDTH:0]   MAX_EXT = MAX[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_W   = MAX[WIDTH-1:0];
    localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;

    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_diff;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH-1:0] load_clamped;
    logic             at_top;
    logic             at_bot;

    always_comb begin
        // Widened by one bit so the MAX comparison sees the carry before truncation.
        up_sum       = {1'b0, out_q} + ONE_EXT;
        dn_diff      = {1'b0, out_q} - ONE_EXT;
        load_ext     = {1'b0, load_val};
        at_top       = (up_sum > MAX_EXT);
        at_bot       = (out_q == '0);
        load_clamped = (load_ext > MAX_EXT) ? MAX_W : load_val;
    end

    always_comb begin
        out_d = out_q;
        tc_d  = 1'b0;
        if (load) begin
            out_d = load_clamped;
        end else if (en) begin
            if (sel) begin
                if (at_top) begin
                    tc_d = 1'b1;
`ifdef UPDN_CNT_SAT_EN
                    out_d = MAX_W;
`else
                    out_d = '0;
`endif
                end else begin
                    out_d = up_sum[WIDTH-1:0];
                end
            end else begin
                if (at_bot) begin
                    tc_d = 1'b1;
`ifdef UPDN_CNT_SAT_EN
                    out_d = '0;
`else
                    out_d = MAX_W;
`endif
                end else begin
                    out_d = dn_diff[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
        end
    end

    assign out = out_q;
    assign tc  = tc_q;

endmodule

// File: tb/tb_updn_counter_mod.sv
// Directed bench for updn_counter_mod: a WIDTH=4/MAX=9 instance and a default-parameter instance.
// Expectations follow the build mode selected by UPDN_CNT_SAT_EN.
module tb_updn_counter_mod;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sel;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] out9, outf;
    logic       tc9, tcf;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    updn_counter_mod #(.WIDTH(4), .MAX(9)) dut (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .load(load),
        .load_val(load_val), .out(out9), .tc(tc9)
    );

    updn_counter_mod dut_d (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .load(load),
        .load_val(load_val), .out(outf), .tc(tcf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; sel = 1'b1; load = 1'b0; load_val = '0;
        #12;
        check("rst_out", out9, 0);
        check("rst_tc", tc9, 0);
        check("rst_out_d", outf, 0);
        #8 rst = 1'b0;

        // Count up across the MAX=9 boundary
        en = 1'b1; sel = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
`ifdef UPDN_CNT_SAT_EN
            check($sformatf("up_out%0d", i), out9, (i <= 9) ? i : 9);
            check($sformatf("up_tc%0d", i), tc9, (i >= 10) ? 1 : 0);
`else
            check($sformatf("up_out%0d", i), out9, i % 10);
            check($sformatf("up_tc%0d", i), tc9, (i == 10) ? 1 : 0);
`endif
        end

        // Load 2 then count down across zero
        load = 1'b1; load_val = 4'd2; step();
        check("ld2_out", out9, 2);
        check("ld2_tc", tc9, 0);
        load = 1'b0; sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] eo;
            logic       et;
`ifdef UPDN_CNT_SAT_EN
            eo = (i < 2) ? 4'(1 - i) : 4'd0;
            et = (i >= 2);
`else
            eo = (i < 2) ? 4'(1 - i) : 4'(11 - i);
            et = (i == 2);
`endif
            step();
            check($sformatf("dn_out%0d", i), out9, eo);
            check($sformatf("dn_tc%0d", i), tc9, et);
        end

        // Load above MAX clamps and wins over en
        load = 1'b1; load_val = 4'd14; sel = 1'b0; step();
        check("clamp_out", out9, 9);
        check("clamp_tc", tc9, 0);
        load = 1'b0; sel = 1'b1; step();
`ifdef UPDN_CNT_SAT_EN
        check("clamp_nx_out", out9, 9);
`else
        check("clamp_nx_out", out9, 0);
`endif
        check("clamp_nx_tc", tc9, 1);

        // Down from zero for three edges, then turn up
        load = 1'b1; load_val = 4'd0; step();
        check("ld0_out", out9, 0);
        load = 1'b0; sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
`ifdef UPDN_CNT_SAT_EN
            check($sformatf("sat_out%0d", i), out9, 0);
            check($sformatf("sat_tc%0d", i), tc9, 1);
`else
            check($sformatf("sat_out%0d", i), out9, 9 - i);
            check($sformatf("sat_tc%0d", i), tc9, (i == 0) ? 1 : 0);
`endif
        end
        sel = 1'b1; step();
`ifdef UPDN_CNT_SAT_EN
        check("turn_out", out9, 1);
`else
        check("turn_out", out9, 8);
`endif
        check("turn_tc", tc9, 0);

        // Hold with en=0, load in range with en=0
        en = 1'b0; step();
        check("hold_tc", tc9, 0);
        load = 1'b1; load_val = 4'd3; step();
        check("ld3_out", out9, 3);
        load = 1'b0; step();
        check("hold_out", out9, 3);

        // Async reset between edges aborts a pending count
        load = 1'b1; load_val = 4'd5; step();
        check("ld5_out", out9, 5);
        load = 1'b0; en = 1'b1; sel = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_out", out9, 0);
        check("arst_tc", tc9, 0);
        en = 1'b0;
        @(negedge clk) rst = 1'b0;
        step();
        check("post_rst_out", out9, 0);
        check("post_rst_tc", tc9, 0);

        // Default parameters: natural 4-bit rollover
        en = 1'b1; sel = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            check($sformatf("def_out%0d", i), outf, i % 16);
            check($sformatf("def_tc%0d", i), tcf, (i == 16) ? 1 : 0);
        end

        // Direction toggled every edge from 7
        load = 1'b1; load_val = 4'd7; step();
        check("def_ld7", outf, 7);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel = ((i % 2) == 0);
            step();
            check($sformatf("tog_out%0d", i), outf, ((i % 2) == 0) ? 8 : 7);
            check($sformatf("tog_tc%0d", i), tcf, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
